booth_multiplier_seq: RTL and testbench

- Sequential signed radix-2 Booth multiplier. It is the multiply-side companion to the datapath's sequential restoring divider.
- Takes two N-bit two's-complement operands on a start/ready handshake and produces a 2N-bit signed product after N iteration cycles.
- Sits beside the divider in the arithmetic unit and shares its operand buses and control sequencer.

---
 rtl/booth_multiplier_seq_if.sv | 23 ++
 rtl/booth_multiplier_seq.sv | 126 ++++++++++++
 tb/tb_booth_multiplier_seq.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/booth_multiplier_seq_if.sv
// rtl/booth_multiplier_seq_if.sv - start/ready operand and product bundle for the Booth multiplier
interface booth_multiplier_seq_if #(
    parameter int N = 16
);
    logic             start;
    logic [N-1:0]     multiplicand;
    logic [N-1:0]     multiplier;
    logic [2*N-1:0]   product;
    logic             busy;
    logic             ready;

    // Requester side: issues operands, observes result and status
    modport master (
        output start, multiplicand, multiplier,
        input  product, busy, ready
    );

    // Multiplier side
    modport slave (
        input  start, multiplicand, multiplier,
        output product, busy, ready
    );
endinterface

// File: rtl/booth_multiplier_seq.sv
// rtl/booth_multiplier_seq.sv - sequential signed radix-2 Booth multiplier, N steps per product
module booth_multiplier_seq #(
    parameter int N  = 16,
    parameter int CW = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    booth_multiplier_seq_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    state_t          state_q, state_d;
    // A and M carry one guard bit so that negating M = -2^(N-1) cannot overflow
    logic [N:0]      m_q, m_d;
    logic [N:0]      a_q, a_d;
    logic [N-1:0]    q_q, q_d;
    logic            q1_q, q1_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*N-1:0]  product_q, product_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;
    logic [N:0]      sum;
    logic            load;

    // Booth recoding of the current multiplier bit pair selects add, subtract or hold
    always_comb begin
        sum = a_q;
        case ({q_q[0], q1_q})
            2'b01:   sum = a_q + m_q;
            2'b10:   sum = a_q - m_q;
            default: sum = a_q;
        endcase
    end

    // Next-state and datapath control; new operands may be taken in IDLE or in DONE
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        a_d       = a_q;
        q_d       = q_q;
        q1_d      = q1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        busy_d    = busy_q;
        ready_d   = 1'b0;
        load      = 1'b0;

        case (state_q)
            S_IDLE: begin
                load = bus.start;
            end
            S_RUN: begin
                // Arithmetic shift right of {A, Q, q_1} after the add/subtract
                a_d   = {sum[N], sum[N:1]};
                q_d   = {sum[0], q_q[N-1:1]};
                q1_d  = q_q[0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                product_d = {a_q[N-1:0], q_q};
                ready_d   = 1'b1;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
                load      = bus.start;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            m_d     = {bus.multiplicand[N-1], bus.multiplicand};
            a_d     = '0;
            q_d     = bus.multiplier;
            q1_d    = 1'b0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = S_RUN;
        end
    end

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            m_q       <= m_d;
            a_q       <= a_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.product = product_q;
    assign bus.busy    = busy_q;
    assign bus.ready   = ready_q;
endmodule

// File: tb/tb_booth_multiplier_seq.sv
// tb/tb_booth_multiplier_seq.sv - self-checking bench for booth_multiplier_seq
module tb_booth_multiplier_seq;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    booth_multiplier_seq_if #(.N(N)) bus ();

    booth_multiplier_seq #(.N(N), .CW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: a product appears N+1 edges after the accepting edge; starts
    // are honoured only when no operation is outstanding (or on its final edge)
    int          remaining;
    logic [31:0] pend, prod_exp;
    logic        busy_exp, ready_exp;
    logic        accept_m;

    assign accept_m = bus.start && (remaining <= 1);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            remaining <= 0;
            pend      <= '0;
            prod_exp  <= '0;
            busy_exp  <= 1'b0;
            ready_exp <= 1'b0;
        end else begin
            if (remaining == 1) begin
                prod_exp  <= pend;
                ready_exp <= 1'b1;
            end else begin
                ready_exp <= 1'b0;
            end
            if (accept_m) begin
                pend      <= $signed({{N{bus.multiplicand[N-1]}}, bus.multiplicand}) *
                             $signed({{N{bus.multiplier[N-1]}}, bus.multiplier});
                remaining <= N + 1;
                busy_exp  <= 1'b1;
            end else if (remaining > 0) begin
                remaining <= remaining - 1;
                if (remaining == 1) begin
                    busy_exp <= 1'b0;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    // One clock; outputs sampled on the falling edge and compared to the reference
    task automatic step();
        @(negedge clk);
        check("busy",    32'(bus.busy),  32'(busy_exp));
        check("ready",   32'(bus.ready), 32'(ready_exp));
        check("product", bus.product,    prod_exp);
    endtask

    task automatic wait_ready(input int limit, output int cyc);
        cyc = 0;
        while (cyc < limit) begin
            step();
            cyc++;
            if (bus.ready) break;
        end
    endtask

    task automatic run_op(input logic [15:0] mc, input logic [15:0] mp,
                          input logic [31:0] lit, input string nm);
        int cyc;
        int busy_n;
        bit seen;
        bus.multiplicand = mc;
        bus.multiplier   = mp;
        bus.start        = 1'b1;
        step();
        bus.start        = 1'b0;
        bus.multiplicand = 16'($urandom);
        bus.multiplier   = 16'($urandom);
        cyc    = 1;
        busy_n = bus.busy ? 1 : 0;
        seen   = 1'b0;
        while (!seen && cyc < 60) begin
            step();
            cyc++;
            if (bus.ready) seen = 1'b1;
            else if (bus.busy) busy_n++;
        end
        check({nm, " ready_cycle"}, 32'(cyc), 32'(N + 2));
        check({nm, " busy_cycles"}, 32'(busy_n), 32'(N + 1));
        check({nm, " product"}, bus.product, lit);
        step();
        check({nm, " ready_pulse"}, 32'(bus.ready), 32'd0);
        check({nm, " hold"}, bus.product, lit);
    endtask

    initial begin
        int c1, c2;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;

        // Reset held for three cycles
        repeat (3) step();
        check("reset product", bus.product, 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset ready", 32'(bus.ready), 32'd0);
        rst = 1'b1;
        repeat (5) step();
        check("idle ready", 32'(bus.ready), 32'd0);

        // Basic product and signed corners
        run_op(16'd3,    16'd7,      32'h0000_0015, "3x7");
        run_op(16'hFFFB, 16'd9,      32'hFFFF_FFD3, "-5x9");
        run_op(16'h8000, 16'h8000,   32'h4000_0000, "min_x_min");
        run_op(16'h7FFF, 16'h8000,   32'hC000_8000, "max_x_min");
        run_op(16'h0000, 16'h1234,   32'h0000_0000, "zero");

        // Start during RUN is ignored
        bus.multiplicand = 16'd3;
        bus.multiplier   = 16'd4;
        bus.start        = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (3) step();
        bus.multiplicand = 16'd100;
        bus.multiplier   = 16'd100;
        bus.start        = 1'b1;
        step();
        bus.start = 1'b0;
        wait_ready(40, c1);
        check("ignore product", bus.product, 32'd12);
        check("ignore ready_cycle", 32'(c1), 32'(N + 2 - 5));
        repeat (20) step();
        check("ignore no_second_ready", 32'(bus.ready), 32'd0);
        run_op(16'd5, 16'd6, 32'd30, "after_ignore");

        // Back-to-back with start held high
        bus.multiplicand = 16'd2;
        bus.multiplier   = 16'd3;
        bus.start        = 1'b1;
        step();
        bus.multiplicand = 16'hFFFF;
        bus.multiplier   = 16'hFFFF;
        wait_ready(40, c1);
        check("b2b first product", bus.product, 32'd6);
        check("b2b first busy", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        wait_ready(40, c2);
        check("b2b spacing", 32'(c2), 32'(N + 1));
        check("b2b second product", bus.product, 32'd1);
        repeat (3) step();

        // Mid-operation reset
        bus.multiplicand = 16'd1000;
        bus.multiplier   = 16'd1000;
        bus.start        = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (7) step();
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("async product", bus.product, 32'd0);
        check("async busy", 32'(bus.busy), 32'd0);
        check("async ready", 32'(bus.ready), 32'd0);
        repeat (2) step();
        rst = 1'b1;
        step();
        run_op(16'd2, 16'd2, 32'd4, "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no summary required summary");
        $fatal(1, "timeout");
    end
endmodule
